// File: rtl/spi_move_exchange.sv
// Move link to the Arduino opponent: detects one new human move, sends it over SPI mode 0,
// polls for the reply cell and strobes it out. Optional macro MOVE_PARITY_EN adds odd parity.
module spi_move_exchange #(
    parameter int CLK_DIV    = 25,
    parameter int GAP_CYCLES = 50000,
    parameter int MAX_POLLS  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] matrix,
    input  logic        load,
    input  logic        enable,
    input  logic        miso,
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n,
    output logic [4:0]  move_index,
    output logic [3:0]  reply_cell,
    output logic        reply_valid,
    output logic        busy,
    output logic        error
);
    typedef enum logic [2:0] {IDLE, SEND, GAP, POLL, CHECK, ECHO} state_t;

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int PW = $clog2(MAX_POLLS + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] POLL_MAX = PW'(MAX_POLLS);

    state_t          state;
    logic            load_d;
    logic [17:0]     shadow;
    logic [DW-1:0]   div_cnt;
    logic [4:0]      ph;
    logic [7:0]      tx_sr, rx_sr;
    logic [GW-1:0]   gap_cnt;
    logic [PW-1:0]   poll_cnt;
    logic [8:0]      chg;
    logic [4:0]      new_idx;
    logic            rx_empty, multi_chg, rx_ok, rx_bad, frame_tick, frame_end;
    logic [7:0]      tx_move, tx_poll;
    logic            unused_rx;

    always_comb begin
        chg      = '0;
        new_idx  = '0;
        rx_empty = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chg[i] = (shadow[2*i +: 2] == 2'b00) && (matrix[2*i +: 2] != 2'b00);
            if (chg[i]) new_idx = {matrix[2*i+1] & ~matrix[2*i], 4'(i)};
            if (rx_sr[3:0] == 4'(i)) rx_empty = (matrix[2*i +: 2] == 2'b00);
        end
    end

    assign multi_chg  = (chg & (chg - 9'd1)) != 9'd0;
    assign rx_ok      = (rx_sr[3:0] <= 4'd8) && rx_empty;
    assign frame_tick = (div_cnt == DIV_LAST);
    assign frame_end  = frame_tick && (ph == 5'd17);
    assign unused_rx  = ^{rx_sr[7], rx_sr[5:4]};

`ifdef MOVE_PARITY_EN
    assign tx_move = {~^{2'b00, new_idx}, 2'b00, new_idx};
    assign tx_poll = 8'h80;
    assign rx_bad  = ~^rx_sr;
`else
    assign tx_move = {3'b000, new_idx};
    assign tx_poll = 8'h00;
    assign rx_bad  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            load_d      <= 1'b0;
            shadow      <= '0;
            div_cnt     <= '0;
            ph          <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            gap_cnt     <= '0;
            poll_cnt    <= '0;
            cs_n        <= 1'b1;
            sclk        <= 1'b0;
            mosi        <= 1'b0;
            move_index  <= '0;
            reply_cell  <= '0;
            reply_valid <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b0;
        end else begin
            load_d      <= load;
            reply_valid <= 1'b0;
            if (load_d) shadow <= matrix;

            // Phase 0 and 17 are the cs_n holds; odd phases 1..15 are sclk-low halves.
            if (state == SEND || state == POLL) begin
                if (frame_tick) begin
                    div_cnt <= '0;
                    if (ph == 5'd17) begin
                        cs_n <= 1'b1;
                        mosi <= 1'b0;
                    end else begin
                        ph <= ph + 5'd1;
                        if (ph[0]) begin
                            sclk  <= 1'b1;
                            rx_sr <= {rx_sr[6:0], miso};
                        end else if (ph != 5'd0) begin
                            sclk  <= 1'b0;
                            tx_sr <= {tx_sr[6:0], 1'b0};
                            mosi  <= tx_sr[6];
                        end
                    end
                end else begin
                    div_cnt <= div_cnt + DW'(1);
                end
            end

            case (state)
                IDLE: if (load_d && enable) begin
                    if (multi_chg) begin
                        error <= 1'b1;
                    end else if (chg != 9'd0) begin
                        move_index <= new_idx;
                        error      <= 1'b0;
                        busy       <= 1'b1;
                        poll_cnt   <= '0;
                        cs_n       <= 1'b0;
                        ph         <= '0;
                        div_cnt    <= '0;
                        tx_sr      <= tx_move;
                        mosi       <= tx_move[7];
                        state      <= SEND;
                    end
                end
                SEND: if (frame_end) begin
                    gap_cnt <= '0;
                    state   <= GAP;
                end
                GAP: if (gap_cnt == GAP_LAST) begin
                    poll_cnt <= poll_cnt + PW'(1);
                    cs_n     <= 1'b0;
                    ph       <= '0;
                    div_cnt  <= '0;
                    tx_sr    <= tx_poll;
                    mosi     <= tx_poll[7];
                    state    <= POLL;
                end else begin
                    gap_cnt <= gap_cnt + GW'(1);
                end
                POLL: if (frame_end) begin
                    if (rx_bad || (!rx_sr[6] && poll_cnt == POLL_MAX)) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (rx_sr[6]) begin
                        state <= CHECK;
                    end else begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end
                end
                CHECK: if (rx_ok) begin
                    reply_cell  <= rx_sr[3:0];
                    reply_valid <= 1'b1;
                    state       <= ECHO;
                end else begin
                    error <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                // The Arduino's own move comes back as the next load; swallow it.
                ECHO: if (load_d || !enable) begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/spi_move_exchange.md
# spi_move_exchange

Move link between the game-board register and the external Arduino opponent over SPI. It watches the 18-bit board for a newly placed human move and encodes it as a 5-bit move index. It sends the move in an SPI frame, polls until the Arduino acknowledges a reply cell, validates that cell against the board, and hands it to the matrix controller as a one-cycle strobe. It sits downstream of the matrix register and upstream of the matrix-control write path.

## Interface
Parameters:
- CLK_DIV, 25, clk cycles per SCLK half-period (≥1).
- GAP_CYCLES, 50000, idle clk cycles between consecutive frames.
- MAX_POLLS, 16, poll frames sent before declaring timeout (≥1).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- matrix  in  18  board; cell i = bits[2i+1:2i]; 00 empty, 01 player 1, 10 player 2.
- load  in  1  matrix register load strobe; the new matrix is valid the cycle after load.
- enable  in  1  exchange allowed (versus-Arduino game state).
- miso  in  1  SPI data from Arduino.
- sclk  out  1  SPI clock, idle low (mode 0).
- mosi  out  1  SPI data to Arduino, MSB first.
- cs_n  out  1  SPI chip select, active low.
- move_index  out  5  last sent move {player, cell[3:0]}; player = 1 for code 10.
- reply_cell  out  4  validated opponent cell 0..8.
- reply_valid  out  1  one-cycle strobe; reply_cell valid.
- busy  out  1  high from move detection to return to IDLE.
- error  out  1  sticky; cleared on the next detected move or on rst.

## Operation
- Shadow board (18 bits) holds the last accepted matrix. Comparison happens in the cycle after load (load_d).
- Change set = cells whose shadow is 00 and whose matrix is non-00. The shadow is updated to matrix on every load_d, whatever the state.
- States: IDLE, SEND, GAP, POLL, CHECK, ECHO.
- IDLE, load_d, enable=1:
  - 0 changes: no action.
  - 1 change: latch move_index, clear error, busy=1, go to SEND.
  - ≥2 changes: error=1, stay IDLE.
- IDLE, load_d, enable=0: absorb the change (shadow only).
- SEND: TX byte = {P, 2'b00, move_index}. The RX byte is discarded. Go to GAP.
- GAP: count GAP_CYCLES, then POLL.
- POLL: TX byte = {P, 7'b0}. On RX:
  - bit6 = 1: go to CHECK.
  - bit6 = 0, poll count < MAX_POLLS: go to GAP.
  - bit6 = 0, poll count = MAX_POLLS: error=1, go to IDLE.
- CHECK (1 cycle):
  - RX[3:0] ≤ 8 and matrix cell empty: reply_cell = RX[3:0], reply_valid=1, go to ECHO.
  - Otherwise: error=1, go to IDLE.
- ECHO: the next load_d is absorbed without sending (the Arduino's own move written back). Then go to IDLE with busy=0. enable falling in ECHO also returns to IDLE.
- Loads during SEND/GAP/POLL update the shadow only and never start a frame.
- P = 0 unless MOVE_PARITY_EN is defined.

## Timing
- Frame, mode 0, MSB first:
  - cs_n falls, then one CLK_DIV hold.
  - 8 SCLK periods of 2·CLK_DIV each. mosi changes while sclk is low; miso is sampled on the rising sclk edge.
  - One CLK_DIV hold, then cs_n rises.
  - Frame length = 18·CLK_DIV cycles.
- First frame: cs_n falls 1 cycle after load_d (2 cycles after load).
- reply_valid is asserted 1 cycle after the last frame's cs_n rise. It always lasts exactly one cycle.
- Reset values: cs_n=1, sclk=0, mosi=0, reply_valid=0, reply_cell=0, move_index=0, busy=0, error=0, shadow=0, state IDLE.
- rst mid-frame: on the next edge cs_n=1 and sclk=0; the frame is abandoned with no reply.
- load_d coinciding with the CHECK cycle: the shadow updates. The CHECK emptiness test uses the matrix sampled in that same cycle.

## Configuration
- MOVE_PARITY_EN defined:
  - TX bit7 = P, chosen so the byte has odd parity.
  - A received poll byte with even parity is treated as bad: error=1, go to IDLE.
  - Parity applies to all RX bytes in POLL.
- Undefined: TX bit7 = 0 and RX bit7 is ignored.

## Test plan
- CLK_DIV=2, GAP_CYCLES=4, MAX_POLLS=3. Load matrix with cell 4 = 01. Arduino returns 0x00, then 0x47 (parity macro undefined).
  - Required: MOSI frame 0x04, then two poll frames 0x00.
  - reply_valid is a 1-cycle pulse with reply_cell=7, 1 cycle after the third cs_n rise.
- Reply 0x44 while cell 4 is occupied -> error=1, no reply_valid, busy=0.
- Arduino always returns 0x00 -> exactly 3 poll frames, then error=1 and cs_n stays high.
- One load sets cells 0 and 8 from 00 -> error=1, no cs_n activity.
- Load writing cell 7 = 10 after reply_valid -> absorbed in ECHO, no frame. A following human move on cell 2 sends 0x02.
- With MOVE_PARITY_EN, first frame is 0x04. Assert rst at cycle 10 of that frame -> cs_n=1 and sclk=0 next edge, all outputs return to reset values.
